// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: reset PC, word width, FSM encoding and buffer entry layout.
package inst_fetch_ctrl_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Fetch sequencer states
  // state   | meaning
  // ST_IDLE | no new reads issued; buffer and in-flight word still drain
  // ST_RUN  | reads issued whenever the buffer has room
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: control inputs, instruction memory port and consumer handshake.
interface inst_fetch_ctrl_if;
  import inst_fetch_ctrl_pkg::*;

  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_rena;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              misalign_err;

  // Fetch controller side
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_rena, imem_addr, inst_valid, inst_out, inst_pc, misalign_err
  );

  // Environment side (memory, pipeline control, consumer)
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_rena, imem_addr, inst_valid, inst_out, inst_pc, misalign_err
  );

endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// inst_fifo: synchronous buffer of {pc, inst} entries with flush, push, pop and count.
// Flush wins over push/pop. Storage is cleared only by reset, so the head reads
// zero until the first push.
module inst_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Entry storage: written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues sequential word reads, buffers returned
// words with their PC, and handles redirects (flush + kill of the in-flight read).
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  inst_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issue_pc;
  logic              inflight;
  logic              misalign;
  logic              rena;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [OCC_W-1:0]  occupancy;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // A handshake in a redirect cycle is not a consumption: the flush discards the head.
  assign pop  = ~empty & bus.inst_ready & ~bus.redirect_valid;
  // The response to last cycle's read arrives now; a redirect kills it.
  assign push = inflight & ~bus.redirect_valid;

  // Entries the buffer will hold after this edge if nothing new is issued.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

  assign push_entry.pc   = issue_pc;
  assign push_entry.inst = bus.imem_rdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and read-issue decision.
  always_comb begin
    state_next = state;
    rena       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.fetch_en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.fetch_en) state_next = ST_IDLE;
        rena = ~bus.redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Fetch address: redirect target beats the sequential increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     fetch_pc <= word_align(RESET_PC);
    else if (bus.redirect_valid) fetch_pc <= word_align(bus.redirect_pc);
    else if (rena)               fetch_pc <= fetch_pc + 32'd4;
  end

  // Track the single outstanding read and the PC it was issued for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      issue_pc <= '0;
    end else begin
      inflight <= rena;
      if (rena) issue_pc <= fetch_pc;
    end
  end

  // Sticky misaligned-redirect flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               misalign <= 1'b0;
    else if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign bus.imem_rena    = rena;
  assign bus.imem_addr    = fetch_pc;
  assign bus.inst_valid   = ~empty;
  assign bus.inst_out     = head_entry.inst;
  assign bus.inst_pc      = head_entry.pc;
  assign bus.misalign_err = misalign;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a queue-based reference model.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ordered list of buffered words plus one outstanding read.
  bit           m_run;
  logic [31:0]  m_pc;
  logic [31:0]  m_iss_pc;
  bit           m_inflight;
  bit           m_err;
  fetch_entry_t m_q[$];
  bit           m_pop;
  bit           exp_rena;
  bit           exp_valid;
  fetch_entry_t exp_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [98:0] obs_vec();
    return {bus.imem_rena, bus.imem_addr, bus.inst_valid,
            bus.inst_valid ? bus.inst_pc : 32'h0,
            bus.inst_valid ? bus.inst_out : 32'h0, bus.misalign_err};
  endfunction

  function automatic logic [98:0] exp_vec();
    return {exp_rena, m_pc, exp_valid, exp_head.pc, exp_head.inst, m_err};
  endfunction

  task automatic model_reset();
    m_run      = 1'b0;
    m_pc       = RPC;
    m_iss_pc   = '0;
    m_inflight = 1'b0;
    m_err      = 1'b0;
    m_q.delete();
  endtask

  // Apply one cycle of inputs on the falling edge and derive the expected outputs.
  task automatic drive(input bit r, input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    int occ;
    @(negedge clk);
    rst                = r;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = rdy;
    bus.imem_rdata     = m_inflight ? mem_word(m_iss_pc) : 32'hDEAD_BEEF;
    if (r) model_reset();
    #1;
    exp_valid = (m_q.size() != 0);
    exp_head  = exp_valid ? m_q[0] : '0;
    m_pop     = exp_valid && rdy;
    occ       = m_q.size() - int'(m_pop) + int'(m_inflight);
    exp_rena  = !r && m_run && !rv && (occ < DEPTH);
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    fetch_entry_t e;
    @(posedge clk);
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.redirect_valid) begin
      m_q.delete();
      m_inflight = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) m_err = 1'b1;
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_inflight) begin
        e.pc   = m_iss_pc;
        e.inst = mem_word(m_iss_pc);
        m_q.push_back(e);
      end
      m_inflight = exp_rena;
      if (exp_rena) begin
        m_iss_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    m_run = bus.fetch_en;
  endtask

  task automatic test_reset();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 32'h0, 1);
      n_vec++;
      if ({bus.imem_rena, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.misalign_err} !== 67'h0) begin
        n_err++;
        $display("FAIL reset_outputs c%0d: got %h want 0", c,
                 {bus.imem_rena, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.misalign_err});
      end
      n_vec++;
      if (bus.imem_addr !== RPC) begin
        n_err++;
        $display("FAIL reset_addr c%0d: got %h want %h", c, bus.imem_addr, RPC);
      end
      advance();
    end
  endtask

  task automatic test_first_fetch();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL first_fetch c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 0) begin
        n_vec++;
        if (bus.imem_rena !== 1'b0) begin
          n_err++;
          $display("FAIL first_fetch_idle: rena got %b want 0", bus.imem_rena);
        end
      end
      if (c == 1) begin
        n_vec++;
        if ({bus.imem_rena, bus.imem_addr} !== {1'b1, 32'h0040_0000}) begin
          n_err++;
          $display("FAIL first_fetch_issue: got %b/%h want 1/00400000", bus.imem_rena, bus.imem_addr);
        end
      end
      if (c == 2) begin
        n_vec++;
        if (bus.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL first_fetch_early_valid: got %b want 0", bus.inst_valid);
        end
      end
      if (c == 3) begin
        n_vec++;
        if ({bus.inst_valid, bus.inst_pc, bus.inst_out} !== {1'b1, 32'h0040_0000, mem_word(32'h0040_0000)}) begin
          n_err++;
          $display("FAIL first_fetch_valid: got %b/%h/%h want 1/00400000/%h",
                   bus.inst_valid, bus.inst_pc, bus.inst_out, mem_word(32'h0040_0000));
        end
      end
      advance();
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL throughput i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h0040_0004 + 32'(4 * i)}) begin
        n_err++;
        $display("FAIL throughput_seq i%0d: got %b/%h want 1/%h", i, bus.inst_valid, bus.inst_pc,
                 32'h0040_0004 + 32'(4 * i));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL backpressure i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({bus.imem_rena, bus.inst_pc, bus.inst_out} !== {1'b0, 32'h0040_0024, mem_word(32'h0040_0024)}) begin
        n_err++;
        $display("FAIL backpressure_hold i%0d: got %b/%h/%h want 0/00400024", i,
                 bus.imem_rena, bus.inst_pc, bus.inst_out);
      end
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL release i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h0040_0024 + 32'(4 * i)}) begin
        n_err++;
        $display("FAIL release_seq i%0d: got %b/%h want 1/%h", i, bus.inst_valid, bus.inst_pc,
                 32'h0040_0024 + 32'(4 * i));
      end
      advance();
    end
  endtask

  // Redirect to target and verify the first word delivered afterwards.
  task automatic redirect_and_expect(input string name, input logic [31:0] target, input logic [31:0] first_pc);
    bit found = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL %s_fill i%0d: got %h want %h", name, i, obs_vec(), exp_vec());
      end
      advance();
    end
    drive(0, 1, 1, target, 1);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL %s_pulse: got %h want %h", name, obs_vec(), exp_vec());
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL %s i%0d: got %h want %h", name, i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_vec++;
        if (bus.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s_flush: inst_valid got %b want 0", name, bus.inst_valid);
        end
      end
      if (!found && bus.inst_valid === 1'b1) begin
        found = 1;
        n_vec++;
        if ({bus.inst_pc, bus.inst_out} !== {first_pc, mem_word(first_pc)}) begin
          n_err++;
          $display("FAIL %s_target: got %h/%h want %h/%h", name, bus.inst_pc, bus.inst_out,
                   first_pc, mem_word(first_pc));
        end
      end
      advance();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: inst_valid got 0 want 1", name);
    end
  endtask

  task automatic test_redirect_full();
    redirect_and_expect("redirect_full", 32'h0040_0100, 32'h0040_0100);
  endtask

  task automatic test_misalign();
    redirect_and_expect("misalign", 32'h0040_0102, 32'h0040_0100);
    n_vec++;
    if (bus.misalign_err !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_sticky: got %b want 1", bus.misalign_err);
    end
  endtask

  task automatic test_idle_redirect();
    bit seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, (i >= 6), (i == 4), 32'h0040_0800, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL idle_redirect i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i >= 1 && i <= 6) begin
        n_vec++;
        if (bus.imem_rena !== 1'b0) begin
          n_err++;
          $display("FAIL idle_no_read i%0d: rena got %b want 0", i, bus.imem_rena);
        end
      end
      if (i == 7) begin
        seen = 1;
        n_vec++;
        if ({bus.imem_rena, bus.imem_addr} !== {1'b1, 32'h0040_0800}) begin
          n_err++;
          $display("FAIL idle_resume: got %b/%h want 1/00400800", bus.imem_rena, bus.imem_addr);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    int k = 0;
    seq[0] = 32'hFFFF_FFF8;
    seq[1] = 32'hFFFF_FFFC;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0004;
    drive(0, 1, 1, 32'hFFFF_FFF8, 1);
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL wrap i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.imem_rena === 1'b1 && k < 4) begin
        n_vec++;
        if (bus.imem_addr !== seq[k]) begin
          n_err++;
          $display("FAIL wrap_addr k%0d: got %h want %h", k, bus.imem_addr, seq[k]);
        end
        k++;
      end
      advance();
    end
    if (k < 4) begin
      n_vec++;
      n_err++;
      $display("FAIL wrap_timeout: issued %0d want 4", k);
    end
  endtask

  task automatic test_reset_midstream();
    bit found = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      advance();
    end
    drive(1, 1, 0, 32'h0, 1);
    n_vec++;
    if ({bus.imem_rena, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.misalign_err} !== 67'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h want 0",
               {bus.imem_rena, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.misalign_err});
    end
    advance();
    drive(1, 1, 0, 32'h0, 1);
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midreset_restart i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (!found && bus.inst_valid === 1'b1) begin
        found = 1;
        n_vec++;
        if ({bus.inst_pc, bus.inst_out} !== {32'h0040_0000, mem_word(32'h0040_0000)}) begin
          n_err++;
          $display("FAIL midreset_first: got %h/%h want 00400000/%h", bus.inst_pc, bus.inst_out,
                   mem_word(32'h0040_0000));
        end
      end
      advance();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL midreset_timeout: inst_valid got 0 want 1");
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit fe, rv, rdy;
    for (int i = 0; i < 400; i++) begin
      fe  = ($urandom % 8) != 0;
      rv  = ($urandom % 12) == 0;
      rdy = ($urandom % 4) != 0;
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16))
                                  : (32'h0040_0000 + ($urandom % 1024));
      drive(0, fe, rv, rpc, rdy);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    rst                = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b0;
    #2 rst = 1'b1;
    test_reset();
    test_first_fetch();
    test_throughput();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_idle_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
